stopwatch_counter: RTL and testbench
====================================

Name: stopwatch_counter

Overview:
Timekeeping core of the stopwatch; sits directly upstream of display_time and drives its min1/min0/sec1/sec0 BCD digit inputs.
- Counts MM:SS on a 1 Hz enable pulse; supports pause/resume.
- Adjust mode advances the selected field (minutes or seconds) at 2 Hz with no carry.
- Exports an adjust blink phase so the display path can flash the field being adjusted.

Parameters:
MAX_MIN, 59, highest minute value before minutes wrap to 0; legal range 1..79 (min1 is 3 bits).
MAX_SEC, 59, highest second value before seconds wrap to 0 and carry into minutes; fixed at 59 in normal use.

Ports:
clk  input  1  system clock, single clock domain.
rst  input  1  synchronous active-high reset.
tick_1hz  input  1  one-cycle enable pulse, once per second.
tick_2hz  input  1  one-cycle enable pulse, twice per second.
pause_pulse  input  1  debounced one-cycle pulse; toggles run/pause.
adj  input  1  level; 1 = adjust mode.
sel  input  1  level; adjust target: 0 = minutes, 1 = seconds.
min1  output  3  minutes tens digit, BCD 0..7.
min0  output  4  minutes units digit, BCD 0..9.
sec1  output  3  seconds tens digit, BCD 0..5.
sec0  output  4  seconds units digit, BCD 0..9.
paused  output  1  1 while in PAUSE state.
blink_phase  output  1  toggles on each tick_2hz while adj=1; 0 when adj=0.

Behaviour:
- Clock and reset:
  - Reset is synchronous and active-high; the single clock is clk.
  - rst dominates every other input in the same cycle.
- Reset values: min1=0, min0=0, sec1=0, sec0=0, paused=0 (state RUN), blink_phase=0.
- Outputs: all registered. A change sampled at clock edge N is visible after edge N; one-cycle latency from the pulse.
- State machine, two states RUN and PAUSE:
  - pause_pulse=1 toggles the state: RUN<->PAUSE.
  - The toggle is honoured in both normal and adjust modes.
- Normal mode (adj=0):
  - RUN with tick_1hz=1: increment MM:SS by one second.
  - sec0 wraps 9->0 and carries to sec1; sec1 wraps 5->0 and carries to minutes.
  - Minutes count 0..MAX_MIN. At MAX_MIN:59, the next tick gives 00:00 (full wrap).
  - PAUSE: tick_1hz is ignored and digits hold.
  - tick_2hz is ignored in normal mode.
- Adjust mode (adj=1):
  - tick_1hz is ignored.
  - tick_2hz=1 increments only the selected field by 1, whether in RUN or PAUSE.
  - sel=1: seconds go 0..MAX_SEC, then wrap to 0 with no carry into minutes.
  - sel=0: minutes go 0..MAX_MIN, then wrap to 0; seconds are untouched.
  - sel is sampled in the same cycle as tick_2hz.
- blink_phase:
  - Toggles on each tick_2hz while adj=1.
  - Cleared to 0 in the cycle after adj is sampled 0.
- Simultaneous events:
  - tick_1hz and pause_pulse in the same cycle while in RUN: the increment occurs and the state becomes PAUSE. The pre-toggle state governs counting.
  - tick_1hz and pause_pulse in the same cycle while in PAUSE: no increment; the state becomes RUN.
  - tick_1hz and tick_2hz in the same cycle: only the mode-appropriate tick is used.
  - adj changing in a cycle: the new adj value governs that cycle.
- Invariant: digits are always valid BCD within their ranges; no intermediate illegal value is ever registered.
- Reset mid-adjust or mid-carry: all outputs go to reset values on the next edge; no partial carry persists.

Decomposition:
- Shared package: constants MAX_SEC_DEF=59, MAX_MIN_DEF=59, and the state encoding (ST_RUN=1'b0, ST_PAUSE=1'b1).
- One sub-module, bcd_mod_counter, instantiated twice (seconds, minutes).
  - Parameter MAX; outputs a 3-bit tens and a 4-bit units digit.
  - Inputs: inc, clr.
  - carry_out is a combinational flag: inc and value==MAX.
- The top level owns the FSM, the mode muxing (carry vs. no-carry) and blink_phase.

Test Plan:
- Reset check: assert rst for 2 cycles with pulses active -> all digits 0, paused=0, blink_phase=0.
- Seconds carry: run 61 tick_1hz pulses from reset -> 01:01 (min0=1, sec1=0, sec0=1).
- Full wrap: preload to 59:58 via adjust, then 2 tick_1hz pulses -> 59:59, then 00:00.
- Pause/resume: pause_pulse, then 5 tick_1hz pulses -> digits unchanged, paused=1. Another pause_pulse, then 1 tick_1hz -> +1 s, paused=0.
- Adjust seconds: adj=1, sel=1 at 00:58, 3 tick_2hz pulses -> 00:59, 00:00, 00:01 (no minute carry). blink_phase toggles 3 times; tick_1hz is ignored.
- Same-cycle events: tick_1hz with pause_pulse in RUN at 00:09 -> 00:10 and paused=1. Then adj=1, sel=0, tick_2hz at minute 59 -> minutes 00, seconds held at 10.

Source files
------------

// File: rtl/stopwatch_counter_pkg.sv
// rtl/stopwatch_counter_pkg.sv - shared constants and run/pause state encoding for the stopwatch core
package stopwatch_counter_pkg;
   localparam int MAX_SEC_DEF = 59;
   localparam int MAX_MIN_DEF = 59;

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_PAUSE = 1'b1
   } state_e;
endpackage

// File: rtl/stopwatch_counter_if.sv
// rtl/stopwatch_counter_if.sv - control pulses in, BCD time digits and status out
interface stopwatch_counter_if;
   logic       tick_1hz;
   logic       tick_2hz;
   logic       pause_pulse;
   logic       adj;
   logic       sel;
   logic [2:0] min1;
   logic [3:0] min0;
   logic [2:0] sec1;
   logic [3:0] sec0;
   logic       paused;
   logic       blink_phase;

   modport slave (
      input  tick_1hz, tick_2hz, pause_pulse, adj, sel,
      output min1, min0, sec1, sec0, paused, blink_phase
   );

   modport master (
      output tick_1hz, tick_2hz, pause_pulse, adj, sel,
      input  min1, min0, sec1, sec0, paused, blink_phase
   );
endinterface

// File: rtl/stopwatch_counter_bcd_mod_counter.sv
// rtl/stopwatch_counter_bcd_mod_counter.sv - two-digit BCD counter 0..MAX that wraps to 0
module bcd_mod_counter
   import stopwatch_counter_pkg::*;
#(
   parameter int MAX = MAX_SEC_DEF
) (
   input  logic       clk_i,
   input  logic       clr_i,
   input  logic       inc_i,
   output logic [2:0] tens_o,
   output logic [3:0] units_o,
   output logic       carry_out_o
);
   localparam logic [2:0] MAX_T = 3'(MAX / 10);
   localparam logic [3:0] MAX_U = 4'(MAX % 10);

   logic [2:0] tens_q, tens_d;
   logic [3:0] units_q, units_d;
   logic       at_max;

   assign at_max      = (tens_q == MAX_T) && (units_q == MAX_U);
   assign carry_out_o = inc_i && at_max;

   // Wrap is decided on the whole value so no digit ever passes through an out-of-range code.
   always_comb begin
      tens_d  = tens_q;
      units_d = units_q;
      if (inc_i) begin
         if (at_max) begin
            tens_d  = 3'd0;
            units_d = 4'd0;
         end else if (units_q == 4'd9) begin
            tens_d  = tens_q + 3'd1;
            units_d = 4'd0;
         end else begin
            units_d = units_q + 4'd1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (clr_i) begin
         tens_q  <= 3'd0;
         units_q <= 4'd0;
      end else begin
         tens_q  <= tens_d;
         units_q <= units_d;
      end
   end

   assign tens_o  = tens_q;
   assign units_o = units_q;
endmodule

// File: rtl/stopwatch_counter.sv
// rtl/stopwatch_counter.sv - MM:SS stopwatch core with run/pause FSM, no-carry adjust mode and blink phase
module stopwatch_counter
   import stopwatch_counter_pkg::*;
#(
   parameter int MAX_MIN = MAX_MIN_DEF,
   parameter int MAX_SEC = MAX_SEC_DEF
) (
   input logic                 clk,
   input logic                 rst,
   stopwatch_counter_if.slave  sw
);
   state_e state_q, state_d;
   logic   blink_q, blink_d;
   logic   sec_inc, min_inc, sec_carry, run_tick;

   // Counting is gated by the pre-toggle state; adjust mode never carries.
   assign run_tick = !sw.adj && (state_q == ST_RUN) && sw.tick_1hz;
   assign sec_inc  = sw.adj ? (sw.tick_2hz && sw.sel) : run_tick;
   assign min_inc  = sw.adj ? (sw.tick_2hz && !sw.sel) : sec_carry;

   bcd_mod_counter #(.MAX(MAX_SEC)) u_sec (
      .clk_i       (clk),
      .clr_i       (rst),
      .inc_i       (sec_inc),
      .tens_o      (sw.sec1),
      .units_o     (sw.sec0),
      .carry_out_o (sec_carry)
   );

   bcd_mod_counter #(.MAX(MAX_MIN)) u_min (
      .clk_i       (clk),
      .clr_i       (rst),
      .inc_i       (min_inc),
      .tens_o      (sw.min1),
      .units_o     (sw.min0),
      .carry_out_o ()
   );

   always_comb begin
      state_d = state_q;
      blink_d = 1'b0;
      if (sw.pause_pulse) begin
         state_d = (state_q == ST_RUN) ? ST_PAUSE : ST_RUN;
      end
      if (sw.adj) begin
         blink_d = blink_q ^ sw.tick_2hz;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_RUN;
         blink_q <= 1'b0;
      end else begin
         state_q <= state_d;
         blink_q <= blink_d;
      end
   end

   assign sw.paused      = (state_q == ST_PAUSE);
   assign sw.blink_phase = blink_q;
endmodule

// File: tb/tb_stopwatch_counter.sv
// tb/tb_stopwatch_counter.sv - directed vector table plus hand sequences for stopwatch_counter
module tb_stopwatch_counter;
   typedef struct {
      logic r, t1, t2, pp, a, sl;
      int   m, s;
      logic p, b;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   vec_t tbl[19];

   stopwatch_counter_if sw_if ();

   stopwatch_counter #(.MAX_MIN(59), .MAX_SEC(59)) dut (
      .clk (clk),
      .rst (rst),
      .sw  (sw_if)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(logic r, logic t1, logic t2, logic pp, logic a, logic sl,
                               int m, int s, logic p, logic b);
      vec_t v;
      v.r = r; v.t1 = t1; v.t2 = t2; v.pp = pp; v.a = a; v.sl = sl;
      v.m = m; v.s = s; v.p = p; v.b = b;
      return v;
   endfunction

   task automatic cyc(input logic r, input logic t1, input logic t2, input logic pp,
                      input logic a, input logic sl);
      @(negedge clk);
      rst = r;
      sw_if.tick_1hz = t1;
      sw_if.tick_2hz = t2;
      sw_if.pause_pulse = pp;
      sw_if.adj = a;
      sw_if.sel = sl;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input int m, input int s, input logic p, input logic b);
      logic [13:0] exp_t, got_t;
      exp_t = {3'(m / 10), 4'(m % 10), 3'(s / 10), 4'(s % 10)};
      got_t = {sw_if.min1, sw_if.min0, sw_if.sec1, sw_if.sec0};
      checks++;
      if (got_t !== exp_t) begin
         errors++;
         $display("FAIL %s digits: got %0d%0d:%0d%0d expected %0d%0d:%0d%0d", name,
                  got_t[13:11], got_t[10:7], got_t[6:4], got_t[3:0],
                  exp_t[13:11], exp_t[10:7], exp_t[6:4], exp_t[3:0]);
      end
      checks++;
      if (sw_if.paused !== p) begin
         errors++;
         $display("FAIL %s paused: got %b expected %b", name, sw_if.paused, p);
      end
      checks++;
      if (sw_if.blink_phase !== b) begin
         errors++;
         $display("FAIL %s blink_phase: got %b expected %b", name, sw_if.blink_phase, b);
      end
   endtask

   initial begin
      sw_if.tick_1hz = 1'b0;
      sw_if.tick_2hz = 1'b0;
      sw_if.pause_pulse = 1'b0;
      sw_if.adj = 1'b0;
      sw_if.sel = 1'b0;

      //            r  t1 t2 pp a  sl  m  s  p  b
      tbl[0]  = mk(1, 1, 1, 1, 1, 0,  0, 0, 0, 0);
      tbl[1]  = mk(1, 1, 1, 1, 1, 0,  0, 0, 0, 0);
      tbl[2]  = mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 0);
      tbl[3]  = mk(0, 1, 0, 0, 0, 0,  0, 1, 0, 0);
      tbl[4]  = mk(0, 0, 1, 0, 0, 0,  0, 1, 0, 0);
      tbl[5]  = mk(0, 0, 0, 1, 0, 0,  0, 1, 1, 0);
      tbl[6]  = mk(0, 1, 0, 0, 0, 0,  0, 1, 1, 0);
      tbl[7]  = mk(0, 1, 0, 1, 0, 0,  0, 1, 0, 0);
      tbl[8]  = mk(0, 1, 0, 0, 0, 0,  0, 2, 0, 0);
      tbl[9]  = mk(0, 1, 0, 0, 1, 1,  0, 2, 0, 0);
      tbl[10] = mk(0, 0, 1, 0, 1, 1,  0, 3, 0, 1);
      tbl[11] = mk(0, 0, 1, 0, 1, 0,  1, 3, 0, 0);
      tbl[12] = mk(0, 0, 1, 1, 1, 0,  2, 3, 1, 1);
      tbl[13] = mk(0, 0, 1, 0, 1, 1,  2, 4, 1, 0);
      tbl[14] = mk(0, 0, 0, 0, 1, 1,  2, 4, 1, 0);
      tbl[15] = mk(0, 0, 1, 0, 1, 1,  2, 5, 1, 1);
      tbl[16] = mk(0, 0, 0, 0, 0, 0,  2, 5, 1, 0);
      tbl[17] = mk(0, 0, 0, 1, 0, 0,  2, 5, 0, 0);
      tbl[18] = mk(1, 0, 1, 0, 1, 0,  0, 0, 0, 0);

      for (int i = 0; i < 19; i++) begin
         cyc(tbl[i].r, tbl[i].t1, tbl[i].t2, tbl[i].pp, tbl[i].a, tbl[i].sl);
         chk($sformatf("vec%0d", i), tbl[i].m, tbl[i].s, tbl[i].p, tbl[i].b);
      end

      // Seconds carry: 61 ticks from 00:00 end at 01:01
      for (int i = 1; i <= 61; i++) begin
         cyc(0, 1, 0, 0, 0, 0);
         chk($sformatf("carry%0d", i), i / 60, i % 60, 0, 0);
      end

      // Preload 59:58 via adjust, then full wrap
      for (int i = 1; i <= 57; i++) begin
         cyc(0, 0, 1, 0, 1, 1);
         chk($sformatf("adj_sec%0d", i), 1, 1 + i, 0, logic'(i % 2));
      end
      for (int j = 1; j <= 58; j++) begin
         cyc(0, 0, 1, 0, 1, 0);
         chk($sformatf("adj_min%0d", j), 1 + j, 58, 0, logic'((57 + j) % 2));
      end
      cyc(0, 0, 0, 0, 0, 0);
      chk("preload", 59, 58, 0, 0);
      cyc(0, 1, 0, 0, 0, 0);
      chk("wrap_5959", 59, 59, 0, 0);
      cyc(0, 1, 0, 0, 0, 0);
      chk("wrap_0000", 0, 0, 0, 0);

      // Pause / resume
      cyc(0, 0, 0, 1, 0, 0);
      chk("pause", 0, 0, 1, 0);
      for (int i = 0; i < 5; i++) begin
         cyc(0, 1, 0, 0, 0, 0);
         chk($sformatf("paused_tick%0d", i), 0, 0, 1, 0);
      end
      cyc(0, 0, 0, 1, 0, 0);
      chk("resume", 0, 0, 0, 0);
      cyc(0, 1, 0, 0, 0, 0);
      chk("resume_tick", 0, 1, 0, 0);

      // Adjust seconds across the 59->00 wrap with tick_1hz also active
      for (int i = 1; i <= 57; i++) begin
         cyc(0, 0, 1, 0, 1, 1);
      end
      chk("to_0058", 0, 58, 0, 1);
      cyc(0, 1, 1, 0, 1, 1);
      chk("adj_0059", 0, 59, 0, 0);
      cyc(0, 1, 1, 0, 1, 1);
      chk("adj_0000", 0, 0, 0, 1);
      cyc(0, 1, 1, 0, 1, 1);
      chk("adj_0001", 0, 1, 0, 0);
      cyc(0, 0, 0, 0, 0, 0);
      chk("adj_exit", 0, 1, 0, 0);

      // Same-cycle tick + pause at 00:09, then minute wrap in adjust while paused
      for (int i = 1; i <= 8; i++) begin
         cyc(0, 0, 1, 0, 1, 1);
      end
      cyc(0, 0, 0, 0, 0, 0);
      chk("at_0009", 0, 9, 0, 0);
      cyc(0, 1, 0, 1, 0, 0);
      chk("tick_pause", 0, 10, 1, 0);
      for (int i = 1; i <= 59; i++) begin
         cyc(0, 0, 1, 0, 1, 0);
         chk($sformatf("min_adj%0d", i), i, 10, 1, logic'(i % 2));
      end
      cyc(0, 0, 1, 0, 1, 0);
      chk("min_wrap", 0, 10, 1, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
